// File: rtl/add_seq_64.sv
// Multi-cycle wide adder/subtractor: walks a full-width operand pair through one
// 16-bit carry-lookahead slice per cycle, LSB-first, then offers the result on a valid/ready port.

module add_pg_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        carry_in,
    output logic [15:0] sum,
    output logic        carry_out,
    output logic        prop_out,
    output logic        gen_out
);
    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] c;
    logic [3:0]  grp_p;
    logic [3:0]  grp_g;
    logic [3:0]  grp_c;

    assign p = a ^ b;
    assign g = a & b;

    // First level: 4-bit group propagate/generate and in-group carries.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_group
            assign grp_p[gi] = &p[4*gi +: 4];
            assign grp_g[gi] = g[4*gi+3]
                             | (p[4*gi+3] & g[4*gi+2])
                             | (p[4*gi+3] & p[4*gi+2] & g[4*gi+1])
                             | (p[4*gi+3] & p[4*gi+2] & p[4*gi+1] & g[4*gi]);

            assign c[4*gi]   = grp_c[gi];
            assign c[4*gi+1] = g[4*gi]
                             | (p[4*gi] & grp_c[gi]);
            assign c[4*gi+2] = g[4*gi+1]
                             | (p[4*gi+1] & g[4*gi])
                             | (p[4*gi+1] & p[4*gi] & grp_c[gi]);
            assign c[4*gi+3] = g[4*gi+2]
                             | (p[4*gi+2] & g[4*gi+1])
                             | (p[4*gi+2] & p[4*gi+1] & g[4*gi])
                             | (p[4*gi+2] & p[4*gi+1] & p[4*gi] & grp_c[gi]);
        end
    endgenerate

    // Second level: group carries computed directly from the slice carry-in.
    assign grp_c[0] = carry_in;
    assign grp_c[1] = grp_g[0] | (grp_p[0] & carry_in);
    assign grp_c[2] = grp_g[1]
                    | (grp_p[1] & grp_g[0])
                    | (grp_p[1] & grp_p[0] & carry_in);
    assign grp_c[3] = grp_g[2]
                    | (grp_p[2] & grp_g[1])
                    | (grp_p[2] & grp_p[1] & grp_g[0])
                    | (grp_p[2] & grp_p[1] & grp_p[0] & carry_in);

    assign gen_out  = grp_g[3]
                    | (grp_p[3] & grp_g[2])
                    | (grp_p[3] & grp_p[2] & grp_g[1])
                    | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]);
    assign prop_out = &grp_p;

    assign carry_out = grp_g[3] | (grp_p[3] & grp_c[3]);
    assign sum       = p ^ c;
endmodule

module add_seq_64 #(
    parameter int SLICES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [16*SLICES-1:0]   a,
    input  logic [16*SLICES-1:0]   b,
    input  logic                   cin,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [16*SLICES-1:0]   sum,
    output logic                   cout,
    output logic                   ovf
);
    localparam int W  = 16 * SLICES;
    localparam int KW = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(SLICES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    logic [15:0]   a_chunk [SLICES];
    logic [15:0]   b_chunk [SLICES];
    logic [15:0]   a_slice;
    logic [15:0]   b_slice;
    logic [15:0]   slice_sum;
    logic          slice_cout;
    logic          slice_prop;
    logic          slice_gen;

    generate
        for (genvar gi = 0; gi < SLICES; gi++) begin : g_chunk
            assign a_chunk[gi] = a_q[16*gi +: 16];
            assign b_chunk[gi] = b_q[16*gi +: 16];
        end
    endgenerate

    assign a_slice = a_chunk[k_q];
    assign b_slice = b_chunk[k_q];

    add_pg_16 u_slice (
        .a         (a_slice),
        .b         (b_slice),
        .carry_in  (carry_q),
        .sum       (slice_sum),
        .carry_out (slice_cout),
        .prop_out  (slice_prop),
        .gen_out   (slice_gen)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is folded into an add of ~b with carry-in forced high.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < SLICES; i++) begin
                    if (k_q == KW'(i)) begin
                        sum_d[16*i +: 16] = slice_sum;
                    end
                end
                carry_d = slice_cout;
                if (k_q == K_LAST) begin
                    // On the top slice a_slice/b_slice bit 15 are the operand sign bits.
                    cout_d  = slice_cout;
                    ovf_d   = (a_slice[15] == b_slice[15]) && (slice_sum[15] != a_slice[15]);
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // The slice's block propagate/generate must agree with its own carry-out.
    assert property (@(posedge clk) disable iff (rst)
        (state_q != RUN) || (slice_cout == (slice_gen | (slice_prop & carry_q))));

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_add_seq_64.sv
// Self-checking bench for add_seq_64 (SLICES=4): directed corner cases plus
// randomized operations with backpressure, checked against exact-integer arithmetic.

module tb_add_seq_64;
    localparam int SLICES = 4;
    localparam logic signed [65:0] SMAX = 66'sh0_7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [65:0] SMIN = -SMAX - 66'sd1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    add_seq_64 #(.SLICES(SLICES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Reference: exact unsigned and signed integer results, then range tests.
    function automatic void ref_model(input logic [63:0] ta, input logic [63:0] tb_, input logic tcin,
                                      input logic tsub, output logic [63:0] rs, output logic rc,
                                      output logic ro);
        logic signed [65:0] sa;
        logic signed [65:0] sb;
        logic signed [65:0] exact;
        logic [64:0]        wide;
        sa = $signed({{2{ta[63]}}, ta});
        sb = $signed({{2{tb_[63]}}, tb_});
        if (tsub) begin
            exact = sa - sb;
            rs    = ta - tb_;
            rc    = (ta >= tb_);
        end else begin
            wide  = {1'b0, ta} + {1'b0, tb_} + {64'd0, tcin};
            rs    = wide[63:0];
            rc    = wide[64];
            exact = sa + sb + $signed({65'd0, tcin});
        end
        ro = (exact > SMAX) || (exact < SMIN);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one operation from IDLE and completes its output handshake.
    task automatic do_op(input logic [63:0] ta, input logic [63:0] tb_, input logic tcin,
                         input logic tsub, output logic [63:0] rs, output logic rc,
                         output logic ro, output int lat, output bit timed_out);
        in_valid = 1'b1;
        a = ta; b = tb_; cin = tcin; sub = tsub;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        timed_out = !out_valid;
        rs = sum; rc = cout; ro = ovf;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_cmp++; if (in_ready !== 1'b1)   begin n_bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0)  begin n_bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        n_cmp++; if (sum !== 64'd0)       begin n_bad++; $display("FAIL reset sum: got %h want 0", sum); end
        n_cmp++; if (cout !== 1'b0)       begin n_bad++; $display("FAIL reset cout: got %b want 0", cout); end
        n_cmp++; if (ovf !== 1'b0)        begin n_bad++; $display("FAIL reset ovf: got %b want 0", ovf); end
        $display("reset: in_ready=%b out_valid=%b sum=%h", in_ready, out_valid, sum);
    endtask

    task automatic test_add_cin();
        logic [63:0] rs; logic rc, ro; int lat; bit to;
        do_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b1, 1'b0, rs, rc, ro, lat, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL add_cin timeout: got %b want 0", to); end
        n_cmp++; if (rs !== 64'h0000_0000_0001_0001) begin n_bad++; $display("FAIL add_cin sum: got %h want 0000000000010001", rs); end
        n_cmp++; if (rc !== 1'b0) begin n_bad++; $display("FAIL add_cin cout: got %b want 0", rc); end
        n_cmp++; if (ro !== 1'b0) begin n_bad++; $display("FAIL add_cin ovf: got %b want 0", ro); end
        n_cmp++; if (lat !== SLICES) begin n_bad++; $display("FAIL add_cin latency: got %0d want %0d", lat, SLICES); end
        $display("add_cin: sum=%h cout=%b ovf=%b latency=%0d", rs, rc, ro, lat);
    endtask

    task automatic test_ripple();
        logic [63:0] rs; logic rc, ro; int lat; bit to;
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, rs, rc, ro, lat, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL ripple timeout: got %b want 0", to); end
        n_cmp++; if (rs !== 64'd0) begin n_bad++; $display("FAIL ripple sum: got %h want 0", rs); end
        n_cmp++; if (rc !== 1'b1) begin n_bad++; $display("FAIL ripple cout: got %b want 1", rc); end
        n_cmp++; if (ro !== 1'b0) begin n_bad++; $display("FAIL ripple ovf: got %b want 0", ro); end
        $display("ripple: sum=%h cout=%b ovf=%b", rs, rc, ro);
    endtask

    task automatic test_sub_ovf();
        logic [63:0] rs; logic rc, ro; int lat; bit to;
        for (int c = 0; c < 2; c++) begin
            do_op(64'h8000_0000_0000_0000, 64'h1, c[0], 1'b1, rs, rc, ro, lat, to);
            n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL sub_ovf timeout cin=%0d: got %b want 0", c, to); end
            n_cmp++; if (rs !== 64'h7FFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL sub_ovf sum cin=%0d: got %h want 7fffffffffffffff", c, rs); end
            n_cmp++; if (rc !== 1'b1) begin n_bad++; $display("FAIL sub_ovf cout cin=%0d: got %b want 1", c, rc); end
            n_cmp++; if (ro !== 1'b1) begin n_bad++; $display("FAIL sub_ovf ovf cin=%0d: got %b want 1", c, ro); end
            $display("sub_ovf cin=%0d: sum=%h cout=%b ovf=%b", c, rs, rc, ro);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a1, b1, a2, b2, es, held;
        logic ec, eo;
        int wait_cyc;
        a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
        in_valid = 1'b1; a = a1; b = b1; cin = 1'b0; sub = 1'b0;
        step();
        // in_valid stays high with changing junk operands; none of it may be taken.
        wait_cyc = 0;
        while (!out_valid && wait_cyc < 20) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = 1'($urandom);
            step();
            wait_cyc++;
        end
        ref_model(a1, b1, 1'b0, 1'b0, es, ec, eo);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b first valid: got %b want 1", out_valid); end
        n_cmp++; if (sum !== es) begin n_bad++; $display("FAIL b2b first sum: got %h want %h", sum, es); end
        held = sum;
        for (int i = 0; i < 10; i++) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            step();
            n_cmp++; if (sum !== held) begin n_bad++; $display("FAIL b2b stall sum cyc=%0d: got %h want %h", i, sum, held); end
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b stall in_ready cyc=%0d: got %b want 0", i, in_ready); end
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b stall out_valid cyc=%0d: got %b want 1", i, out_valid); end
        end
        a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
        a = a2; b = b2; sub = 1'b1; cin = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b after handshake out_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b after handshake in_ready: got %b want 1", in_ready); end
        step();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b second accept in_ready: got %b want 0", in_ready); end
        in_valid = 1'b0;
        a = '0; b = '0;
        wait_cyc = 0;
        while (!out_valid && wait_cyc < 20) begin
            step();
            wait_cyc++;
        end
        ref_model(a2, b2, 1'b0, 1'b1, es, ec, eo);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b second valid: got %b want 1", out_valid); end
        n_cmp++; if (sum !== es) begin n_bad++; $display("FAIL b2b second sum: got %h want %h", sum, es); end
        n_cmp++; if (cout !== ec) begin n_bad++; $display("FAIL b2b second cout: got %b want %b", cout, ec); end
        n_cmp++; if (ovf !== eo) begin n_bad++; $display("FAIL b2b second ovf: got %b want %b", ovf, eo); end
        $display("back_to_back: first=%h second=%h cout=%b ovf=%b", held, sum, cout, ovf);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] rs; logic rc, ro; int lat; bit to; bit seen;
        in_valid = 1'b1; a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'b1; sub = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrun out_valid: got %b want 0", out_valid); end
        n_cmp++; if (sum !== 64'd0) begin n_bad++; $display("FAIL midrun sum: got %h want 0", sum); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrun in_ready: got %b want 1", in_ready); end
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        out_ready = 1'b0;
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midrun stray result: got %b want 0", seen); end
        do_op(64'd5, 64'd7, 1'b0, 1'b0, rs, rc, ro, lat, to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL midrun fresh timeout: got %b want 0", to); end
        n_cmp++; if (rs !== 64'd12) begin n_bad++; $display("FAIL midrun fresh sum: got %0d want 12", rs); end
        $display("reset_mid_run: fresh 5+7 sum=%0d", rs);
    endtask

    task automatic test_random();
        logic [63:0] ta, tb_, es;
        logic tc, ts, ec, eo;
        int n_acc, n_hs, cyc, n_err0;
        bit done;
        n_acc = 0; n_hs = 0;
        n_err0 = n_bad;
        for (int op = 0; op < 1000; op++) begin
            repeat ($urandom_range(0, 2)) step();
            ta = {$urandom, $urandom}; tb_ = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: ta = '1;
                1: tb_ = 64'h8000_0000_0000_0000;
                2: tb_ = ta;
                default: ;
            endcase
            tc = 1'($urandom); ts = 1'($urandom);
            ref_model(ta, tb_, tc, ts, es, ec, eo);
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rand op=%0d in_ready: got %b want 1", op, in_ready); end
            in_valid = 1'b1; a = ta; b = tb_; cin = tc; sub = ts;
            step();
            n_acc++;
            in_valid = 1'b0;
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            done = 1'b0;
            cyc = 0;
            while (!done && cyc < 40) begin
                out_ready = (cyc >= 20) ? 1'b1 : 1'($urandom);
                if (out_valid && out_ready) begin
                    n_cmp++; if (sum !== es) begin n_bad++; $display("FAIL rand op=%0d sum: got %h want %h", op, sum, es); end
                    n_cmp++; if (cout !== ec) begin n_bad++; $display("FAIL rand op=%0d cout: got %b want %b", op, cout, ec); end
                    n_cmp++; if (ovf !== eo) begin n_bad++; $display("FAIL rand op=%0d ovf: got %b want %b", op, ovf, eo); end
                    n_hs++;
                    done = 1'b1;
                end
                step();
                cyc++;
            end
            out_ready = 1'b0;
            n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL rand op=%0d handshake timeout: got %b want 1", op, done); end
            if (op < 5 || op % 100 == 0)
                $display("random op=%0d a=%h b=%h cin=%b sub=%b sum=%h cout=%b ovf=%b", op, ta, tb_, tc, ts, es, ec, eo);
        end
        n_cmp++; if (n_acc !== n_hs) begin n_bad++; $display("FAIL rand handshake count: got %0d want %0d", n_hs, n_acc); end
        $display("random: %0d accepts, %0d results, %0d new mismatches", n_acc, n_hs, n_bad - n_err0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        test_reset();
        test_add_cin();
        test_ripple();
        test_sub_ovf();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/add_seq_64.md
# add_seq_64

Multi-cycle wide adder/subtractor that feeds a single `add_pg_16` carry-lookahead slice one 16-bit chunk per cycle. It is the operand-staging and carry-chaining stage directly upstream of the 16-bit adder. It accepts a full-width operand pair through a valid/ready handshake and walks the slices LSB-first, registering each 16-bit result and the inter-slice carry. It then presents the full-width sum, carry-out and signed overflow on a valid/ready output port.

## Interface
- `SLICES`, default 4: number of 16-bit slices. Total width `W = 16*SLICES`. Legal range 2–8.
- `clk` input, 1: sole clock, rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `in_valid` input, 1: operand pair and controls are valid.
- `in_ready` output, 1: block can accept an operation.
- `a` input, W: operand A.
- `b` input, W: operand B.
- `cin` input, 1: carry-in. Used only when `sub`=0.
- `sub` input, 1: 1 computes A − B as A + ~B + 1. In this mode `cin` is ignored.
- `out_valid` output, 1: result fields are valid.
- `out_ready` input, 1: consumer accepts the result.
- `sum` output, W: result modulo 2^W.
- `cout` output, 1: carry out of bit W−1.
- `ovf` output, 1: signed two's-complement overflow.

## Operation
- FSM has three states: IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, latch A, B' and c0, then go to RUN with slice index k=0.
  - B' = `sub` ? ~b : b. c0 = `sub` ? 1 : `cin`.
- **RUN**
  - Each cycle, drive the instantiated `add_pg_16` with A[16k+15:16k], B'[16k+15:16k] and the carry register.
  - Register the slice result into `sum[16k+15:16k]` and the adder's `carry_out` into the carry register.
  - Increment k.
  - When k=SLICES−1, also capture `cout` = final carry and compute `ovf`, then go to DONE.
- **DONE**
  - `out_valid`=1. `sum`, `cout` and `ovf` are held stable until `out_valid`&&`out_ready`.
  - On that handshake, go to IDLE.
- Overflow rule: `ovf` = (A[W−1] == B'[W−1]) && (sum[W−1] != A[W−1]). This uses the latched B', so it is correct for both add and subtract.
- Input handshake rules:
  - `in_ready`=0 in RUN and DONE. There is one operation in flight at a time, with no overlap.
  - `in_valid` asserted outside IDLE is ignored. Inputs are sampled only at the accept edge.
- Output handshake rules:
  - `out_valid` never drops without a handshake.
  - `out_ready` outside DONE has no effect.
- The `add_pg_16` `prop_out`/`gen_out` outputs are unused.
- Reset:
  - `rst`=1 at any edge forces IDLE and k=0.
  - It also clears the carry register, `sum`, `cout`, `ovf` and `out_valid` to 0, and sets `in_ready` to 1 from the next cycle.
  - Reset mid-RUN or mid-DONE discards the operation with no output handshake.
  - `rst` has priority over simultaneous `in_valid` or `out_ready`.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `sum`=0, `cout`=0, `ovf`=0.
- Accept on edge T. Slices 0..SLICES−1 are registered on edges T+1..T+SLICES. `out_valid`=1 from edge T+SLICES, i.e. SLICES cycles of latency.
- With `out_ready` held at 1:
  - The output handshake occurs on edge T+SLICES+1 and `in_ready` rises that same edge.
  - The next accept occurs on edge T+SLICES+2. Peak throughput is one operation per SLICES+2 cycles.
- Back-to-back: `in_valid` held continuously is accepted exactly once per operation. The second operand is sampled at its own accept edge.
- Output stall: while `out_ready`=0, the block stays in DONE indefinitely with all outputs stable.
- Partial `sum` bits may change during RUN. Consumers must qualify them with `out_valid`.
- Combinational path: each cycle has one `add_pg_16` plus the carry register mux. There is no path from `in_valid` or `out_ready` to any output.

## Test plan
- **Add, cin=1:** SLICES=4, `a`=0x0000_0000_0000_FFFF, `b`=0x1, `cin`=1, `sub`=0.
  - Expect `sum`=0x0000_0000_0001_0001, `cout`=0, `ovf`=0.
  - `out_valid` rises exactly 4 cycles after accept.
- **Full carry ripple:** `a`=0xFFFF_FFFF_FFFF_FFFF, `b`=0x1, `cin`=0.
  - Expect `sum`=0, `cout`=1, `ovf`=0. The carry propagates through all 4 slices.
- **Subtract with overflow:** `sub`=1, `a`=0x8000_0000_0000_0000, `b`=0x1.
  - Expect `sum`=0x7FFF_FFFF_FFFF_FFFF, `cout`=1, `ovf`=1.
  - `cin`=1 or 0 gives the identical result.
- **Output stall and back-to-back:** hold `out_ready`=0 for 10 cycles in DONE, with `in_valid` held high and new operands driven.
  - `sum` must stay stable and `in_ready` must stay 0.
  - After `out_ready`=1, exactly one handshake occurs, then the new operands are accepted on the following edge.
- **Reset mid-RUN:** assert `rst` in cycle 2 of RUN.
  - Next cycle: `out_valid`=0, `sum`=0, `in_ready`=1, and no result is emitted.
  - A fresh add of 5+7 then yields `sum`=12.
- **Random vs. model:** 1000 random a/b/cin/sub operations with random `out_ready` backpressure.
  - Every `sum`, `cout` and `ovf` matches the W-bit reference model.
  - Accept and output handshake counts are equal.
